instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the address assigned to the first emitted word after reset or clear.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port clear, input, 1, synchronous restart of address and error counter.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the field-bundle handshake.
REQ-006 SHALL have port selectLine, input, 2, format select: 00 I, 01 S, 10 B, 11 R (no immediate).
REQ-007 SHALL have ports opcode (input, 7), funct3 (input, 3), funct7 (input, 7), rd, rs1 and rs2 (input, 5 each).
REQ-008 SHALL have port immediate, input, 32, the sign-extended byte-offset/value to pack.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), instruction (output, 32) and out_addr (output, 32).
REQ-010 SHALL have ports err (output, 1), a one-cycle reject pulse, and err_cnt (output, 8), the saturating reject count.

Function
REQ-011 SHALL accept a bundle when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, no bubble under continuous flow).
REQ-012 SHALL present the packed word on instruction exactly 1 cycle after acceptance, with out_valid high.
REQ-013 SHALL pack I as {imm[11:0], rs1, funct3, rd, opcode}; funct7, rs2 ignored.
REQ-014 SHALL pack S as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd, funct7 ignored.
REQ-015 SHALL pack B as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; rd, funct7 ignored.
REQ-016 SHALL pack R as {funct7, rs2, rs1, funct3, rd, opcode}; immediate ignored.
REQ-017 SHALL hold instruction, out_addr and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL drive out_addr with an internal address counter; the counter advances by 4 on each out_valid && out_ready, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-019 SHALL, when clear is asserted, discard any held output word, drop out_valid, set the counter to BASE_ADDR and err_cnt to 0 on the next edge; an input offered in the same cycle is not accepted (in_ready low while clear).
REQ-020 SHALL give simultaneous output handshake and input acceptance both effect in one cycle: counter advances, new word loaded.

Reset
REQ-021 SHALL, on rst, immediately set out_valid=0, instruction=0, out_addr=BASE_ADDR, err=0, err_cnt=0, independent of clk.
REQ-022 SHALL discard any word held mid-handshake when rst asserts; first accepted bundle after release emits at BASE_ADDR.

Configuration
REQ-023 SHALL, with macro IMM_RANGE_CHECK_EN defined, reject a bundle whose immediate is not representable: I/S require immediate[31:11] all equal; B requires immediate[31:12] all equal and immediate[0]=0; R never rejected.
REQ-024 SHALL, on reject, consume the bundle, emit no word, leave the counter unchanged, pulse err for 1 cycle and increment err_cnt saturating at 255.
REQ-025 SHALL, without IMM_RANGE_CHECK_EN, silently truncate out-of-range immediates, with err tied 0 and err_cnt tied 0.

Structure
REQ-026 SHALL take format-select encodings (FMT_I/S/B/R) and RISC-V opcode constants from a shared package also used by the immediate decoder.
REQ-027 SHALL place packing in one combinational sub-module, imm_packer (fields + select -> 32-bit word), with handshake, counter and error logic in instr_encoder.

Verification
REQ-028 I: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> instruction=0x00500093, out_addr=BASE_ADDR, 1-cycle latency.
REQ-029 S: opcode=0100011, funct3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423; B: opcode=1100011, funct3=000, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
REQ-030 R: opcode=0110011, funct7=0, rs2=2, rs1=1, funct3=0, rd=3 -> 0x002081B3; 3 back-to-back words with out_ready high -> addrs 0,4,8, in_ready never low.
REQ-031 Backpressure: out_ready low 5 cycles -> instruction/out_addr stable, in_ready low; release -> next word at addr+4.
REQ-032 With IMM_RANGE_CHECK_EN: I imm=2048 -> err 1 cycle, err_cnt=1, no out_valid, next word keeps prior addr; B imm=3 -> rejected.
REQ-033 Wrap/reset: BASE_ADDR=32'hFFFF_FFFC, 2 words -> addrs FFFF_FFFC, 0; rst asserted mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared format-select encodings, RISC-V opcode constants and the immediate
// range helper used by the instruction encoder and the immediate decoder.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_R = 2'b11
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // B offsets drop bit 0, so they must be even as well as in range
  function automatic logic imm_fits(input fmt_e fmt, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: ok = (imm[31:11] == {21{imm[31]}});
      FMT_B:        ok = (imm[31:12] == {20{imm[31]}}) && (imm[0] == 1'b0);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational packer: scatters register fields and immediate bits into a
// 32-bit RISC-V word according to the selected format.
module imm_packer
  import instr_encoder_pkg::*;
(
  input  fmt_e        sel,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word
);

  // format-driven field placement
  always_comb begin
    word = 32'h0000_0000;
    case (sel)
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      default: word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one-deep output register with valid/ready handshake,
// word address counter and optional immediate range rejection (IMM_RANGE_CHECK_EN).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  selectLine,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] immediate,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] packed_s;
  logic        fire_s, accept_s, reject_s;

  imm_packer u_packer (
    .sel    (fmt_e'(selectLine)),
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (immediate[12:0]),
    .word   (packed_s)
  );

  assign fire_s   = out_valid_q && out_ready;
  assign in_ready = (!out_valid_q || out_ready) && !clear;
  assign accept_s = in_valid && in_ready;

  // output register and address counter next-state
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    if (clear) begin
      out_valid_d = 1'b0;
      addr_d      = BASE_ADDR;
    end else begin
      if (fire_s) begin
        out_valid_d = 1'b0;
        addr_d      = addr_q + 32'd4;
      end else begin
        addr_d      = addr_q;
      end
      if (accept_s && !reject_s) begin
        out_valid_d = 1'b1;
        instr_d     = packed_s;
      end else begin
        instr_d     = instr_q;
      end
    end
  end

  // output register and address counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'h0000_0000;
      addr_q      <= BASE_ADDR;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign instruction = instr_q;
  assign out_addr    = addr_q;

`ifdef IMM_RANGE_CHECK_EN
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // rejected bundles are still consumed, so they use the normal accept path
  assign reject_s = accept_s && !imm_fits(fmt_e'(selectLine), immediate);

  // reject pulse and saturating reject count next-state
  always_comb begin
    err_d     = reject_s;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      err_d     = 1'b0;
      err_cnt_d = 8'h00;
    end else if (reject_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // reject status state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_imm_hi_s;

  assign reject_s        = 1'b0;
  assign err             = 1'b0;
  assign err_cnt         = 8'h00;
  assign unused_imm_hi_s = ^immediate[31:13];
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized
// traffic compared against a behavioural model of the encoder.
module tb_instr_encoder;

  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] BASE_W = 32'hFFFF_FFFC;

  logic        clk, rst, clear, in_valid, out_ready;
  logic [1:0]  selectLine;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] immediate;
  logic        in_ready, out_valid, err;
  logic [31:0] instruction, out_addr;
  logic [7:0]  err_cnt;
  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_instruction, w_out_addr;
  logic [7:0]  w_err_cnt;

  int checks = 0;
  int errors = 0;

  logic        m_valid;
  logic [31:0] m_word, m_addr;
  logic        m_err;
  int          m_cnt;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .selectLine(selectLine), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  instr_encoder #(.BASE_ADDR(BASE_W)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
    .selectLine(selectLine), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .out_valid(w_out_valid), .out_ready(out_ready), .instruction(w_instruction),
    .out_addr(w_out_addr), .err(w_err), .err_cnt(w_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding built from shifts and masks of the instruction fields.
  function automatic logic [31:0] ref_pack(input logic [1:0] s, input logic [31:0] op,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] d,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] common;
    common = (a << 15) | (f3 << 12) | op;
    case (s)
      2'd0: return ((imm & 32'hFFF) << 20) | common | (d << 7);
      2'd1: return (((imm >> 5) & 32'h7F) << 25) | (b << 20) | common | ((imm & 32'h1F) << 7);
      2'd2: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20)
                   | common | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      default: return (f7 << 25) | (b << 20) | common | (d << 7);
    endcase
  endfunction

  function automatic bit model_fits(input logic [1:0] s, input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
    int si;
    si = $signed(imm);
    if (s == 2'd0 || s == 2'd1) return (si >= -2048) && (si <= 2047);
    if (s == 2'd2) return (si >= -4096) && (si <= 4095) && ((si % 2) == 0);
    return 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_word = 32'h0; m_addr = BASE; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic set_fields(input logic [1:0] s, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
      input logic [31:0] imm);
    selectLine = s; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = a; rs2 = b; immediate = imm;
  endtask

  task automatic rand_fields();
    logic [31:0] imm;
    imm = ($urandom_range(0, 1) == 0) ? 32'($signed(13'($urandom))) : 32'($urandom);
    set_fields(2'($urandom), 7'($urandom), 3'($urandom), 7'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), imm);
  endtask

  // One clock: check in_ready, advance the model, then check the outputs.
  task automatic cycle();
    logic exp_ready, hs, acc, ok;
    logic [31:0] w;
    #1;
    exp_ready = !clear && (!m_valid || out_ready);
    checks++;
    if (in_ready !== exp_ready) begin
      errors++; $display("FAIL in_ready: got %b want %b t=%0t", in_ready, exp_ready, $time);
    end
    hs  = m_valid && out_ready;
    acc = in_valid && exp_ready;
    ok  = model_fits(selectLine, immediate);
    w   = ref_pack(selectLine, 32'(opcode), 32'(funct3), 32'(funct7), 32'(rd), 32'(rs1),
                   32'(rs2), immediate);
    @(posedge clk);
    #1;
    if (clear) begin
      m_valid = 1'b0; m_addr = BASE; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (hs) begin m_valid = 1'b0; m_addr = m_addr + 32'd4; end
      m_err = acc && !ok;
      if (acc && ok) begin m_valid = 1'b1; m_word = w; end
      if (m_err && m_cnt < 255) m_cnt++;
    end
    checks += 5;
    if (out_valid !== m_valid) begin
      errors++; $display("FAIL out_valid: got %b want %b t=%0t", out_valid, m_valid, $time);
    end
    if (out_addr !== m_addr) begin
      errors++; $display("FAIL out_addr: got %h want %h t=%0t", out_addr, m_addr, $time);
    end
    if (w_out_addr !== m_addr + BASE_W) begin
      errors++; $display("FAIL wrap_addr: got %h want %h t=%0t", w_out_addr, m_addr + BASE_W, $time);
    end
    if (err !== m_err) begin
      errors++; $display("FAIL err: got %b want %b t=%0t", err, m_err, $time);
    end
    if (err_cnt !== 8'(m_cnt)) begin
      errors++; $display("FAIL err_cnt: got %0d want %0d t=%0t", err_cnt, m_cnt, $time);
    end
    if (m_valid) begin
      checks++;
      if (instruction !== m_word) begin
        errors++; $display("FAIL instruction: got %h want %h t=%0t", instruction, m_word, $time);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(2'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    model_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || instruction !== 32'h0 || out_addr !== BASE || err !== 1'b0
        || err_cnt !== 8'h00 || w_out_addr !== BASE_W) begin
      errors++;
      $display("FAIL reset_state: got v=%b i=%h a=%h wa=%h e=%b c=%0d want 0/0/%h/%h/0/0",
               out_valid, instruction, out_addr, w_out_addr, err, err_cnt, BASE, BASE_W);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_formats();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h0050_0093; exp_w[1] = 32'h0020_A423;
    exp_w[2] = 32'hFE20_8EE3; exp_w[3] = 32'h0020_81B3;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_fields(2'd0, 7'b0010011, 3'b000, 7'h55, 5'd1, 5'd0, 5'd9, 32'd5);
        1: set_fields(2'd1, 7'b0100011, 3'b010, 7'h2A, 5'd7, 5'd1, 5'd2, 32'd8);
        2: set_fields(2'd2, 7'b1100011, 3'b000, 7'h11, 5'd9, 5'd1, 5'd2, -32'sd4);
        default: set_fields(2'd3, 7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'h1234_5678);
      endcase
      cycle();
      checks += 2;
      if (instruction !== exp_w[i]) begin
        errors++; $display("FAIL fmt%0d_word: got %h want %h", i, instruction, exp_w[i]);
      end
      if (out_addr !== BASE + 32'(4 * i)) begin
        errors++; $display("FAIL fmt%0d_addr: got %h want %h", i, out_addr, BASE + 32'(4 * i));
      end
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    clear = 1'b1; in_valid = 1'b1; rand_fields();
    cycle();
    clear = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(2'd3, 7'b0110011, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 32'($urandom));
      cycle();
      checks++;
      if (out_addr !== 32'(4 * i)) begin
        errors++; $display("FAIL b2b_addr%0d: got %h want %h", i, out_addr, 32'(4 * i));
      end
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] held_w, held_a;
    in_valid = 1'b1; out_ready = 1'b0; rand_fields(); selectLine = 2'd3;
    cycle();
    held_w = m_word; held_a = m_addr;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      cycle();
      checks++;
      if (instruction !== held_w || out_addr !== held_a || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall%0d: got %h@%h v=%b want %h@%h v=1",
                           i, instruction, out_addr, out_valid, held_w, held_a);
      end
    end
    out_ready = 1'b1; selectLine = 2'd3;
    cycle();
    checks++;
    if (out_addr !== held_a + 32'd4) begin
      errors++; $display("FAIL release_addr: got %h want %h", out_addr, held_a + 32'd4);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_wrap();
    clear = 1'b1; in_valid = 1'b0;
    cycle();
    clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1; selectLine = 2'd3;
    cycle();
    checks++;
    if (w_out_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first: got %h want FFFFFFFC", w_out_addr);
    end
    cycle();
    checks++;
    if (w_out_addr !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_second: got %h want 00000000", w_out_addr);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; out_ready = 1'b1; selectLine = 2'd3;
    cycle();
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || w_out_valid !== 1'b0 || out_addr !== BASE || instruction !== 32'h0) begin
      errors++; $display("FAIL async_rst: got v=%b wv=%b a=%h i=%h want 0/0/%h/0",
                         out_valid, w_out_valid, out_addr, instruction, BASE);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; rand_fields(); selectLine = 2'd3;
    cycle();
    checks++;
    if (out_addr !== BASE || out_valid !== 1'b1) begin
      errors++; $display("FAIL post_rst_addr: got %h v=%b want %h v=1", out_addr, out_valid, BASE);
    end
    in_valid = 1'b0;
    cycle();
  endtask

`ifdef IMM_RANGE_CHECK_EN
  task automatic test_range();
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    clear = 1'b0; in_valid = 1'b1;
    set_fields(2'd0, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    cycle();
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reject_i: got e=%b c=%0d v=%b want 1/1/0", err, err_cnt, out_valid);
    end
    set_fields(2'd2, 7'b1100011, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3);
    cycle();
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL reject_b: got e=%b c=%0d want 1/2", err, err_cnt);
    end
    set_fields(2'd0, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    cycle();
    checks++;
    if (err !== 1'b0 || out_addr !== BASE || out_valid !== 1'b1) begin
      errors++; $display("FAIL after_reject: got e=%b a=%h v=%b want 0/%h/1", err, out_addr, out_valid, BASE);
    end
    immediate = 32'h0001_0000;
    for (int i = 0; i < 260; i++) cycle();
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++; $display("FAIL err_sat: got %0d want 255", err_cnt);
    end
    in_valid = 1'b0;
    cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_mid_stall();
`ifdef IMM_RANGE_CHECK_EN
    test_range();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
